// File: rtl/move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : move_sequencer
//  Description : Takes a packed batch of 4-bit move codes and issues them one
//                at a time to the motor driver over a cmd_valid/cmd_done
//                handshake. A fixed settle gap follows every completed move.
//                Reports batch completion, dropped batches and faults.
//  Revision    : 1.0  initial release
// ============================================================================
module move_sequencer #(
    parameter int NUM_SLOTS      = 15,
    parameter int SETTLE_CYCLES  = 1000,
    parameter int TIMEOUT_CYCLES = 1 << 24
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    input  logic [4*NUM_SLOTS-1:0] moves_i,
    input  logic                   new_moves_i,
    input  logic                   cmd_done_i,
    output logic [3:0]             cmd_move_o,
    output logic                   cmd_valid_o,
    output logic                   busy_o,
    output logic                   batch_done_o,
    output logic [3:0]             moves_done_o,
    output logic                   dropped_o,
    output logic                   bad_code_o,
    output logic                   timeout_err_o
);

    localparam int IDX_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES + 1) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SCAN   = 3'd1,
        S_ISSUE  = 3'd2,
        S_SETTLE = 3'd3,
        S_DONE   = 3'd4,
        S_FAULT  = 3'd5
    } state_t;

    state_t                 state_q,       state_d;
    logic [4*NUM_SLOTS-1:0] shadow_q,      shadow_d;
    logic [IDX_W-1:0]       idx_q,         idx_d;
    logic [SET_W-1:0]       settle_q,      settle_d;
    logic [TO_W-1:0]        tcnt_q,        tcnt_d;
    logic [3:0]             cmd_move_q,    cmd_move_d;
    logic                   cmd_valid_q,   cmd_valid_d;
    logic                   batch_done_q,  batch_done_d;
    logic [3:0]             moves_done_q,  moves_done_d;
    logic                   dropped_q,     dropped_d;
    logic                   bad_code_q,    bad_code_d;
    logic                   timeout_err_q, timeout_err_d;

    logic [3:0]             code_w;
    logic                   code_ok_w;
    logic                   code_bad_w;

    // Slot currently addressed by the scan index, and its classification.
    // Codes 2..13 are executable, 0 is a silent filler, 1/14/15 are illegal.
    always_comb begin
        code_w     = shadow_q[{idx_q, 2'b00} +: 4];
        code_ok_w  = (code_w >= 4'd2) && (code_w <= 4'd13);
        code_bad_w = (code_w == 4'd1) || (code_w >= 4'd14);
    end

    // State register and all registered outputs.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q       <= S_IDLE;
            shadow_q      <= '0;
            idx_q         <= '0;
            settle_q      <= '0;
            tcnt_q        <= '0;
            cmd_move_q    <= '0;
            cmd_valid_q   <= 1'b0;
            batch_done_q  <= 1'b0;
            moves_done_q  <= '0;
            dropped_q     <= 1'b0;
            bad_code_q    <= 1'b0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            shadow_q      <= shadow_d;
            idx_q         <= idx_d;
            settle_q      <= settle_d;
            tcnt_q        <= tcnt_d;
            cmd_move_q    <= cmd_move_d;
            cmd_valid_q   <= cmd_valid_d;
            batch_done_q  <= batch_done_d;
            moves_done_q  <= moves_done_d;
            dropped_q     <= dropped_d;
            bad_code_q    <= bad_code_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    // Next-state logic: walks slots from the top index down to 0.
    always_comb begin
        state_d       = state_q;
        shadow_d      = shadow_q;
        idx_d         = idx_q;
        settle_d      = settle_q;
        tcnt_d        = tcnt_q;
        cmd_move_d    = cmd_move_q;
        cmd_valid_d   = cmd_valid_q;
        batch_done_d  = 1'b0;
        moves_done_d  = moves_done_q;
        bad_code_d    = bad_code_q;
        timeout_err_d = timeout_err_q;
        // Any batch offered outside IDLE is refused and reported next cycle.
        dropped_d     = new_moves_i && (state_q != S_IDLE);

        case (state_q)
            S_IDLE: begin
                if (new_moves_i) begin
                    shadow_d     = moves_i;
                    idx_d        = IDX_W'(NUM_SLOTS - 1);
                    moves_done_d = '0;
                    bad_code_d   = 1'b0;
                    state_d      = S_SCAN;
                end
            end

            S_SCAN: begin
                if (code_ok_w) begin
                    cmd_move_d  = code_w;
                    cmd_valid_d = 1'b1;
                    tcnt_d      = '0;
                    state_d     = S_ISSUE;
                end else begin
                    if (code_bad_w) begin
                        bad_code_d = 1'b1;
                    end
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end
            end

            S_ISSUE: begin
                // A completion arriving on the expiry cycle still counts.
                if (cmd_done_i) begin
                    cmd_valid_d  = 1'b0;
                    moves_done_d = moves_done_q + 4'd1;
                    settle_d     = SET_W'(SETTLE_CYCLES - 1);
                    state_d      = S_SETTLE;
                end else if (tcnt_q == TO_W'(TIMEOUT_CYCLES - 1)) begin
                    cmd_valid_d   = 1'b0;
                    timeout_err_d = 1'b1;
                    state_d       = S_FAULT;
                end else begin
                    tcnt_d = tcnt_q + TO_W'(1);
                end
            end

            S_SETTLE: begin
                if (settle_q == '0) begin
                    if (idx_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q - IDX_W'(1);
                        state_d = S_SCAN;
                    end
                end else begin
                    settle_d = settle_q - SET_W'(1);
                end
            end

            S_DONE: begin
                batch_done_d = 1'b1;
                state_d      = S_IDLE;
            end

            S_FAULT: begin
                // Parked until reset; cmd_valid already forced low.
                state_d = S_FAULT;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Output mapping.
    always_comb begin
        cmd_move_o    = cmd_move_q;
        cmd_valid_o   = cmd_valid_q;
        busy_o        = (state_q != S_IDLE);
        batch_done_o  = batch_done_q;
        moves_done_o  = moves_done_q;
        dropped_o     = dropped_q;
        bad_code_o    = bad_code_q;
        timeout_err_o = timeout_err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_move_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_move_sequencer
//  Description : Directed self-checking bench for move_sequencer with a
//                short settle gap (4) and timeout (100).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_move_sequencer;

    localparam int SETTLE  = 4;
    localparam int TIMEOUT = 100;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [59:0] moves = '0;
    logic        new_moves = 1'b0;
    logic        cmd_done = 1'b0;
    logic [3:0]  cmd_move;
    logic        cmd_valid;
    logic        busy;
    logic        batch_done;
    logic [3:0]  moves_done;
    logic        dropped;
    logic        bad_code;
    logic        timeout_err;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    move_sequencer #(
        .NUM_SLOTS      (15),
        .SETTLE_CYCLES  (SETTLE),
        .TIMEOUT_CYCLES (TIMEOUT)
    ) u_dut (
        .clock_i       (clk),
        .reset_i       (rst),
        .moves_i       (moves),
        .new_moves_i   (new_moves),
        .cmd_done_i    (cmd_done),
        .cmd_move_o    (cmd_move),
        .cmd_valid_o   (cmd_valid),
        .busy_o        (busy),
        .batch_done_o  (batch_done),
        .moves_done_o  (moves_done),
        .dropped_o     (dropped),
        .bad_code_o    (bad_code),
        .timeout_err_o (timeout_err)
    );

    // Advance past the next rising edge; inputs change and outputs are read here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a batch for exactly one edge (that edge is E0).
    task automatic start_batch(input logic [59:0] m);
        moves     = m;
        new_moves = 1'b1;
        tick();
        new_moves = 1'b0;
    endtask

    // Ticks until cmd_valid is observed, bounded.
    task automatic wait_valid(output int n);
        n = 0;
        while (!cmd_valid && n < 60) begin
            tick();
            n++;
        end
    endtask

    // Ticks until batch_done is observed, bounded; records any cmd_valid seen.
    task automatic wait_batch_done(output int n, output logic saw_valid);
        n = 0;
        saw_valid = 1'b0;
        while (!batch_done && n < 60) begin
            tick();
            n++;
            if (cmd_valid) saw_valid = 1'b1;
        end
    endtask

    task automatic pulse_done();
        cmd_done = 1'b1;
        tick();
        cmd_done = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        new_moves = 1'b1;
        moves     = 60'h4;
        cmd_done  = 1'b1;
        tick(); tick(); tick();
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %0b want 0", busy); else passes++;
        checks++; if ({cmd_valid, batch_done, dropped, bad_code, timeout_err} !== 5'b0)
            $display("FAIL reset_flags: got %b want 00000", {cmd_valid, batch_done, dropped, bad_code, timeout_err}); else passes++;
        checks++; if ({cmd_move, moves_done} !== 8'h00) $display("FAIL reset_counts: got %h want 00", {cmd_move, moves_done}); else passes++;
        new_moves = 1'b0;
        cmd_done  = 1'b0;
        rst       = 1'b0;
        tick();
    endtask

    task automatic test_single();
        int n;
        start_batch(60'h4);
        wait_valid(n);
        checks++; if (n !== 15) $display("FAIL single_latency: got %0d want 15", n); else passes++;
        checks++; if (cmd_move !== 4'd4) $display("FAIL single_code: got %0d want 4", cmd_move); else passes++;
        tick(); tick();
        pulse_done();
        checks++; if ({cmd_valid, busy} !== 2'b01) $display("FAIL single_after_done: got %b want 01", {cmd_valid, busy}); else passes++;
        for (int i = 0; i < SETTLE; i++) tick();
        checks++; if ({batch_done, busy} !== 2'b01) $display("FAIL single_settle: got %b want 01", {batch_done, busy}); else passes++;
        tick();
        checks++; if ({batch_done, busy, moves_done} !== 6'b10_0001)
            $display("FAIL single_done: got %b want 100001", {batch_done, busy, moves_done}); else passes++;
        tick();
        checks++; if (batch_done !== 1'b0) $display("FAIL single_done_pulse: got %0b want 0", batch_done); else passes++;
    endtask

    task automatic test_three();
        int n;
        logic [3:0] exp_code [3];
        logic [3:0] held;
        exp_code[0] = 4'd4;
        exp_code[1] = 4'd6;
        exp_code[2] = 4'd11;
        start_batch(60'h46B);
        wait_valid(n);
        checks++; if (n !== 13) $display("FAIL three_latency: got %0d want 13", n); else passes++;
        for (int k = 0; k < 3; k++) begin
            checks++; if (cmd_move !== exp_code[k]) $display("FAIL three_code%0d: got %0d want %0d", k, cmd_move, exp_code[k]); else passes++;
            held = cmd_move;
            tick(); tick(); tick();
            checks++; if ({cmd_valid, cmd_move} !== {1'b1, held}) $display("FAIL three_hold%0d: got %b want %b", k, {cmd_valid, cmd_move}, {1'b1, held}); else passes++;
            pulse_done();
            if (k < 2) begin
                wait_valid(n);
                // Gap is the settle period plus the one cycle spent scanning the next slot.
                checks++; if (n !== SETTLE + 1) $display("FAIL three_gap%0d: got %0d want %0d", k, n, SETTLE + 1); else passes++;
            end
        end
        for (int i = 0; i < SETTLE + 1; i++) tick();
        checks++; if ({batch_done, moves_done} !== 5'b1_0011) $display("FAIL three_done: got %b want 10011", {batch_done, moves_done}); else passes++;
        tick();
    endtask

    task automatic test_zero();
        int n;
        logic sv;
        start_batch(60'h0);
        wait_batch_done(n, sv);
        checks++; if (n !== 16) $display("FAIL zero_latency: got %0d want 16", n); else passes++;
        checks++; if (sv !== 1'b0) $display("FAIL zero_no_valid: got %0b want 0", sv); else passes++;
        checks++; if ({busy, moves_done} !== 5'b0) $display("FAIL zero_state: got %b want 00000", {busy, moves_done}); else passes++;
        tick();
    endtask

    task automatic test_bad_code();
        int n;
        logic sv;
        start_batch(60'h4F6);
        wait_valid(n);
        checks++; if (cmd_move !== 4'd4) $display("FAIL bad_first: got %0d want 4", cmd_move); else passes++;
        tick();
        pulse_done();
        wait_valid(n);
        // Settle, skip of slot 1 (F), then issue of slot 0.
        checks++; if (n !== SETTLE + 2) $display("FAIL bad_gap: got %0d want %0d", n, SETTLE + 2); else passes++;
        checks++; if ({cmd_move, bad_code} !== 5'b0110_1) $display("FAIL bad_second: got %b want 01101", {cmd_move, bad_code}); else passes++;
        pulse_done();
        wait_batch_done(n, sv);
        checks++; if ({bad_code, moves_done} !== 5'b1_0010) $display("FAIL bad_sticky: got %b want 10010", {bad_code, moves_done}); else passes++;
        tick();
        start_batch(60'h4);
        checks++; if (bad_code !== 1'b0) $display("FAIL bad_clear: got %0b want 0", bad_code); else passes++;
        wait_valid(n);
        pulse_done();
        wait_batch_done(n, sv);
        tick();
    endtask

    task automatic test_drop();
        int n;
        logic sv;
        start_batch(60'h46);
        wait_valid(n);
        moves     = 60'hD;
        new_moves = 1'b1;
        tick();
        new_moves = 1'b0;
        checks++; if ({dropped, cmd_valid, cmd_move} !== 6'b11_0100) $display("FAIL drop_pulse: got %b want 110100", {dropped, cmd_valid, cmd_move}); else passes++;
        tick();
        checks++; if (dropped !== 1'b0) $display("FAIL drop_one_cycle: got %0b want 0", dropped); else passes++;
        pulse_done();
        tick();
        pulse_done();
        checks++; if ({cmd_valid, moves_done} !== 5'b0_0001) $display("FAIL drop_stray_done: got %b want 00001", {cmd_valid, moves_done}); else passes++;
        wait_valid(n);
        checks++; if (n !== SETTLE - 1) $display("FAIL drop_stray_gap: got %0d want %0d", n, SETTLE - 1); else passes++;
        checks++; if (cmd_move !== 4'd6) $display("FAIL drop_second: got %0d want 6", cmd_move); else passes++;
        pulse_done();
        wait_batch_done(n, sv);
        checks++; if ({batch_done, moves_done} !== 5'b1_0010) $display("FAIL drop_done: got %b want 10010", {batch_done, moves_done}); else passes++;
        tick();
    endtask

    task automatic test_timeout();
        int n;
        start_batch(60'h5);
        wait_valid(n);
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        checks++; if ({cmd_valid, timeout_err} !== 2'b10) $display("FAIL to_before: got %b want 10", {cmd_valid, timeout_err}); else passes++;
        tick();
        checks++; if ({cmd_valid, timeout_err, busy} !== 3'b011) $display("FAIL to_expire: got %b want 011", {cmd_valid, timeout_err, busy}); else passes++;
        pulse_done();
        start_batch(60'h4);
        checks++; if ({dropped, busy, timeout_err, cmd_valid, moves_done} !== 8'b1110_0000)
            $display("FAIL to_fault_hold: got %b want 11100000", {dropped, busy, timeout_err, cmd_valid, moves_done}); else passes++;
        tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({busy, timeout_err, dropped, cmd_valid, cmd_move} !== 8'h00)
            $display("FAIL to_reset: got %b want 00000000", {busy, timeout_err, dropped, cmd_valid, cmd_move}); else passes++;
    endtask

    task automatic test_reset_mid_issue();
        int n;
        logic sv;
        start_batch(60'h7);
        wait_valid(n);
        checks++; if (cmd_move !== 4'd7) $display("FAIL rmi_code: got %0d want 7", cmd_move); else passes++;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if ({cmd_valid, busy} !== 2'b00) $display("FAIL rmi_drop: got %b want 00", {cmd_valid, busy}); else passes++;
        sv = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (batch_done || cmd_valid) sv = 1'b1;
        end
        checks++; if (sv !== 1'b0) $display("FAIL rmi_quiet: got %0b want 0", sv); else passes++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_three();
        test_zero();
        test_bad_code();
        test_drop();
        test_timeout();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
`default_nettype wire
